// File: rtl/stochastic_stream_bank_pkg.sv
// Shared types and constants for the stochastic stream bank: FSM states,
// LFSR feedback mask and the per-channel seed spreading rule.
package stochastic_stream_bank_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Galois feedback for taps 32,22,2,1
  localparam logic [31:0] LFSR_TAP_MASK    = 32'h8020_0003;
  localparam logic [31:0] GOLDEN_SEED_STEP = 32'h9E37_79B9;

  // Spread channel seeds by the golden-ratio step; an all-zero LFSR would lock up.
  function automatic logic [31:0] channel_seed(input logic [31:0] base, input int unsigned k);
    logic [31:0] s;
    s = base ^ (k * GOLDEN_SEED_STEP);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

endpackage

// File: rtl/stochastic_stream_bank_lfsr.sv
// Free-running 32-bit Galois LFSR, loaded with its seed on every reset cycle.
module lfsr_seeded
  import stochastic_stream_bank_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] register
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      register <= SEED;
    end else if (register[0]) begin
      register <= (register >> 1) ^ LFSR_TAP_MASK;
    end else begin
      register <= register >> 1;
    end
  end

endmodule

// File: rtl/stochastic_stream_bank.sv
// Multi-channel stochastic number generator: framed Bernoulli bitstreams
// from latched operands compared against per-channel (or shared) LFSR slices.
module stochastic_stream_bank
  import stochastic_stream_bank_pkg::*;
#(
  parameter int          WIDTH    = 10,
  parameter int          CHANNELS = 4,
  parameter int          LEN_LOG2 = 10,
  parameter int          RAND_LSB = 15,
  parameter logic [31:0] SEED     = 32'hACE1_2468
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               correlated,
  input  logic                               abort,
  input  logic [CHANNELS*WIDTH-1:0]          binary_numbers,
  output logic [CHANNELS-1:0]                stochastic_bits,
  output logic                               stream_valid,
  output logic                               busy,
  output logic                               done,
  output logic [CHANNELS*(LEN_LOG2+1)-1:0]   high_counts,
  output logic [0:0]                         state_dbg
);

  localparam int                 CW        = LEN_LOG2 + 1;
  localparam logic [LEN_LOG2-1:0] CNT_ONE   = LEN_LOG2'(1);
  localparam logic [CW-1:0]       TALLY_ONE = CW'(1);

  // Handshake: start is a one-cycle request honoured only in IDLE; stream_valid
  // qualifies stochastic_bits each cycle; done pulses one cycle after the last bit.
  state_t                      state;
  logic                        corr_q;
  logic [CHANNELS*WIDTH-1:0]   ops_q;
  logic [LEN_LOG2-1:0]         cycle_cnt;
  logic                        last_q;
  logic                        start_accept;
  logic                        run_step;
  logic [CHANNELS-1:0]         cmp;
  logic [WIDTH-1:0]            rand_slice [CHANNELS];

  assign start_accept = (state == IDLE) && start;
  assign run_step     = (state == RUN) && !abort;
  assign busy         = stream_valid;
  assign state_dbg    = state;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [31:0]      lfsr_q;
    logic             lfsr_unused;
    logic [WIDTH-1:0] rand_k;
    logic [CW-1:0]    tally_q;
    logic [CW-1:0]    count_q;

    lfsr_seeded #(.SEED(channel_seed(SEED, k))) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .register (lfsr_q)
    );

    assign lfsr_unused   = ^lfsr_q;
    assign rand_slice[k] = lfsr_q[RAND_LSB +: WIDTH];
    // Correlated mode feeds every comparator from channel 0's random number.
    assign rand_k        = corr_q ? rand_slice[0] : rand_slice[k];
    assign cmp[k]        = rand_k < ops_q[k*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        tally_q <= '0;
        count_q <= '0;
      end else begin
        if (start_accept) begin
          tally_q <= '0;
        end else if (run_step && cmp[k]) begin
          tally_q <= tally_q + TALLY_ONE;
        end
        if (last_q) count_q <= tally_q;
      end
    end

    assign high_counts[k*CW +: CW] = count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      corr_q          <= 1'b0;
      ops_q           <= '0;
      cycle_cnt       <= '0;
      last_q          <= 1'b0;
      stream_valid    <= 1'b0;
      stochastic_bits <= '0;
      done            <= 1'b0;
    end else begin
      done   <= last_q;
      last_q <= 1'b0;
      case (state)
        IDLE: begin
          stream_valid    <= 1'b0;
          stochastic_bits <= '0;
          if (start) begin
            state     <= RUN;
            ops_q     <= binary_numbers;
            corr_q    <= correlated;
            cycle_cnt <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state           <= IDLE;
            stream_valid    <= 1'b0;
            stochastic_bits <= '0;
          end else begin
            stream_valid    <= 1'b1;
            stochastic_bits <= cmp;
            cycle_cnt       <= cycle_cnt + CNT_ONE;
            if (&cycle_cnt) begin
              state  <= IDLE;
              last_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stochastic_stream_bank.sv
// Bench for stochastic_stream_bank: burst-level reference model checked every
// cycle, plus directed scenarios with hand-derived expectations.
module tb_stochastic_stream_bank;
  localparam int          WIDTH    = 10;
  localparam int          CHANNELS = 4;
  localparam int          LEN_LOG2 = 10;
  localparam int          RAND_LSB = 15;
  localparam logic [31:0] SEED     = 32'hACE1_2468;
  localparam int          N        = 1 << LEN_LOG2;
  localparam int          CW       = LEN_LOG2 + 1;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             start = 1'b0;
  logic                             correlated = 1'b0;
  logic                             abort = 1'b0;
  logic [CHANNELS*WIDTH-1:0]        binary_numbers = '0;
  logic [CHANNELS-1:0]              stochastic_bits;
  logic                             stream_valid;
  logic                             busy;
  logic                             done;
  logic [CHANNELS*CW-1:0]           high_counts;
  logic [0:0]                       state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_count = 0;
  int corr_viol  = 0;
  bit chk_en     = 1'b0;
  bit corr_mon   = 1'b0;
  int cap_mode   = 0;
  logic [CHANNELS-1:0] exp_q[$];

  // reference model state
  logic [31:0]         m_lfsr [CHANNELS];
  bit                  m_active, m_pend, m_corr;
  int                  m_remaining;
  int                  m_ops   [CHANNELS];
  int                  m_tally [CHANNELS];
  int                  m_hc    [CHANNELS];
  logic [CHANNELS-1:0] e_bits;
  bit                  e_valid, e_done;

  stochastic_stream_bank #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .LEN_LOG2(LEN_LOG2),
    .RAND_LSB(RAND_LSB), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .correlated(correlated),
    .abort(abort), .binary_numbers(binary_numbers),
    .stochastic_bits(stochastic_bits), .stream_valid(stream_valid),
    .busy(busy), .done(done), .high_counts(high_counts), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] seed_of(input int k);
    logic [31:0] s;
    s = SEED ^ (32'(k) * 32'h9E37_79B9);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic int rnd(input logic [31:0] x);
    return int'((x >> RAND_LSB) & ((32'h1 << WIDTH) - 1));
  endfunction

  function automatic logic [CHANNELS*CW-1:0] model_hc();
    logic [CHANNELS*CW-1:0] v;
    for (int k = 0; k < CHANNELS; k++) v[k*CW +: CW] = CW'(m_hc[k]);
    return v;
  endfunction

  // burst-level model: one step per rising edge
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        m_lfsr[k] = seed_of(k); m_tally[k] = 0; m_hc[k] = 0;
      end
      m_active = 0; m_pend = 0; e_bits = '0; e_valid = 0; e_done = 0;
    end else begin
      e_done = m_pend;
      if (m_pend) for (int k = 0; k < CHANNELS; k++) m_hc[k] = m_tally[k];
      m_pend = 0;
      if (m_active && abort) begin
        m_active = 0; e_valid = 0; e_bits = '0;
      end else if (m_active) begin
        for (int k = 0; k < CHANNELS; k++) begin
          int r;
          r = m_corr ? rnd(m_lfsr[0]) : rnd(m_lfsr[k]);
          e_bits[k] = (r < m_ops[k]);
          if (e_bits[k]) m_tally[k]++;
        end
        e_valid = 1;
        m_remaining--;
        if (m_remaining == 0) begin m_active = 0; m_pend = 1; end
      end else begin
        e_valid = 0; e_bits = '0;
        if (start) begin
          m_active = 1; m_remaining = N; m_corr = correlated;
          for (int k = 0; k < CHANNELS; k++) begin
            m_ops[k] = int'(binary_numbers[k*WIDTH +: WIDTH]);
            m_tally[k] = 0;
          end
        end
      end
      for (int k = 0; k < CHANNELS; k++) m_lfsr[k] = lfsr_next(m_lfsr[k]);
    end
  end

  // compare process: every cycle after the first reset
  initial forever begin
    @(negedge clk);
    if (done) done_count++;
    if (corr_mon && stream_valid && stochastic_bits[0] && !stochastic_bits[1]) corr_viol++;
    if (chk_en) begin
      check("cycle_outputs",
            64'({stochastic_bits, stream_valid, busy, done, high_counts, state_dbg}),
            64'({e_bits, e_valid, e_valid, e_done, model_hc(), m_active}));
      if (cap_mode == 1 && e_valid) exp_q.push_back(e_bits);
      if (cap_mode == 2 && e_valid) begin
        check("replay_avail", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("replay_bits", 64'(stochastic_bits), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; abort = 0;
    @(negedge clk);
    chk_en = 1;
    check("reset_outputs",
          64'({stochastic_bits, stream_valid, busy, done, high_counts, state_dbg}), 64'(0));
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_start(input logic [CHANNELS*WIDTH-1:0] ops, input bit corr, output int s);
    start = 1; binary_numbers = ops; correlated = corr;
    @(negedge clk);
    s = cyc;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin at = cyc; break; end
    end
    check({name, "_seen"}, 64'(at >= 0), 64'(1));
  endtask

  function automatic int hc(input int k);
    return int'(high_counts[k*CW +: CW]);
  endfunction

  initial begin
    int s, s2, at, d0;
    logic [CHANNELS*CW-1:0] hc_before;

    do_reset();

    // independent streams, reference burst captured for the reset replay
    cap_mode = 1;
    do_start({10'd0, 10'd341, 10'd255, 10'd511}, 1'b0, s);
    wait_done("t1_done", 1200, at);
    cap_mode = 0;
    check("t1_latency", 64'(at - s), 64'(1025));
    check("t1_hc0_range", 64'(hc(0) >= 448 && hc(0) <= 576), 64'(1));
    check("t1_hc1_range", 64'(hc(1) >= 208 && hc(1) <= 304), 64'(1));
    check("t1_hc2_range", 64'(hc(2) >= 285 && hc(2) <= 397), 64'(1));
    check("t1_hc3_zero", 64'(hc(3)), 64'(0));

    // correlated streams: bit0 implies bit1
    corr_mon = 1;
    do_start({10'd1023, 10'd0, 10'd600, 10'd300}, 1'b1, s);
    wait_done("t2_done", 1200, at);
    corr_mon = 0;
    check("t2_implication", 64'(corr_viol), 64'(0));
    check("t2_tally_order", 64'(hc(0) <= hc(1)), 64'(1));
    check("t2_hc2_zero", 64'(hc(2)), 64'(0));

    // second start mid-burst is ignored
    repeat (4) @(negedge clk);
    d0 = done_count;
    do_start({10'd100, 10'd200, 10'd300, 10'd400}, 1'b0, s);
    repeat (498) @(negedge clk);
    do_start({10'd900, 10'd900, 10'd900, 10'd900}, 1'b0, s2);
    wait_done("t3_done", 1200, at);
    check("t3_latency", 64'(at - s), 64'(1025));
    repeat (40) @(negedge clk);
    check("t3_single_done", 64'(done_count - d0), 64'(1));

    // abort at cycle 200: no done, counts held
    hc_before = model_hc();
    d0 = done_count;
    do_start({10'd700, 10'd50, 10'd500, 10'd1}, 1'b0, s);
    repeat (199) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t4_valid_drop", 64'(stream_valid), 64'(0));
    repeat (1100) @(negedge clk);
    check("t4_no_done", 64'(done_count - d0), 64'(0));
    check("t4_hc_held", 64'(high_counts), 64'(hc_before));

    // reset mid-burst, then replay must match the first post-reset burst
    do_start({10'd1000, 10'd1000, 10'd1000, 10'd1000}, 1'b0, s);
    repeat (300) @(negedge clk);
    do_reset();
    cap_mode = 2;
    do_start({10'd0, 10'd341, 10'd255, 10'd511}, 1'b0, s);
    wait_done("t5_done", 1200, at);
    cap_mode = 0;
    check("t5_replay_consumed", 64'(exp_q.size()), 64'(0));

    // start in the done cycle, with saturated operands
    do_start({10'd1000, 10'd1, 10'd0, 10'd1023}, 1'b0, s);
    wait_done("t6a_done", 1200, at);
    start = 1; binary_numbers = {10'd1000, 10'd1, 10'd0, 10'd1023}; correlated = 0;
    @(negedge clk);
    s2 = cyc;
    start = 0;
    check("t6_valid_not_yet", 64'(stream_valid), 64'(0));
    @(negedge clk);
    check("t6_valid_next", 64'(stream_valid), 64'(1));
    wait_done("t6b_done", 1200, at);
    check("t6_latency", 64'(at - s2), 64'(1025));
    check("t6_hc0_max_op", 64'(hc(0) >= 1010), 64'(1));
    check("t6_hc1_zero_op", 64'(hc(1)), 64'(0));

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stochastic_stream_bank.md
# stochastic_stream_bank

Multi-channel stochastic number generator: converts CHANNELS binary operands into Bernoulli bitstreams of programmable length for the stochastic-computing neuron datapath. Each channel compares its latched operand against a per-channel LFSR value every cycle. Streams run in framed bursts with a start/done handshake and a per-channel high-bit tally. Streams are statistically independent by default, or share one random source for correlation-dependent operators (min/max via AND/OR).

## Interface
- WIDTH, 10, operand and random-number width
- CHANNELS, 4, number of parallel streams
- LEN_LOG2, 10, stream length = 2^LEN_LOG2 cycles
- RAND_LSB, 15, LSB of the WIDTH-bit slice taken from each 32-bit LFSR; RAND_LSB+WIDTH <= 32
- SEED, 32'hACE1_2468, base LFSR seed
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset: synchronous and active-low
- start  input  1  one-cycle request to begin a burst
- correlated  input  1  1 = all channels use channel 0's random number; sampled with start
- abort  input  1  terminate running burst, no done
- binary_numbers  input  CHANNELS*WIDTH  operands; channel k at [k*WIDTH +: WIDTH]; sampled with start
- stochastic_bits  output  CHANNELS  bitstream outputs, bit k = channel k
- stream_valid  output  1  stochastic_bits are part of the current burst
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse, burst completed
- high_counts  output  CHANNELS*(LEN_LOG2+1)  per-channel count of 1s in last completed burst

## Operation
- FSM: IDLE, RUN. Reset -> IDLE.
- IDLE: start=1 -> latch binary_numbers and correlated, clear cycle counter and tallies, go RUN.
- RUN: each cycle register bit k = (rand_k < operand_k), unsigned WIDTH-bit compare; stream_valid=1; increment tally k when bit k is 1.
- Cycle counter LEN_LOG2 bits; on its terminal value (2^LEN_LOG2-1) emit last bit, go IDLE, pulse done next cycle, copy tallies to high_counts.
- rand_k: channel k LFSR slice [RAND_LSB+WIDTH-1:RAND_LSB]; correlated=1 -> all channels use rand_0.
- Channel k LFSR seed = SEED ^ (k * 32'h9E37_79B9); a zero result is replaced with 32'h1.
- LFSRs: 32-bit Galois, taps 32,22,2,1 (mask 32'h8020_0003), free-running from reset; not reseeded by start.
- operand 0 -> stream all 0; operand 2^WIDTH-1 -> 1 except when rand = 2^WIDTH-1.
- start while RUN: ignored. start and abort together in IDLE: start wins.
- abort in RUN: IDLE next cycle, stream_valid=0, no done, high_counts keep previous value.
- start in the same cycle done is high: accepted (state already IDLE).
- Reset mid-burst: everything to reset values, burst lost, LFSRs reseeded.

## Timing
- Reset values: stochastic_bits=0, stream_valid=0, busy=0, done=0, high_counts=0, state IDLE.
- start sampled at edge 0; first valid bit at edge 1; last at edge 2^LEN_LOG2.
- busy=1 from edge 1 through edge 2^LEN_LOG2 (coincides with stream_valid).
- done=1 and high_counts updated at edge 2^LEN_LOG2+1; high_counts held until next completed burst.
- Minimum start-to-start: 2^LEN_LOG2+1 cycles.
- stochastic_bits=0 whenever stream_valid=0.

## Structure
- Shared package: FSM state enum (IDLE, RUN), LFSR tap mask constant, golden-ratio seed constant.
- One sub-module: lfsr_seeded (parameter SEED, ports clk, rst_n, register[31:0]), instantiated CHANNELS times.
- Comparators, tallies and FSM in the top module via generate loop.

## Test plan
- Operands 511, 255, 341, 0, LEN_LOG2=10, correlated=0 -> done at cycle 1025; high_counts 512±64, 256±48, 341±56, exactly 0.
- correlated=1, ch0=300, ch1=600 -> every valid cycle bit0=1 implies bit1=1; tally0 <= tally1.
- start pulsed at cycles 1 and 500 -> single burst; done exactly once at cycle 1026.
- abort at cycle 200 of a burst -> stream_valid=0 next cycle, no done, high_counts unchanged.
- rst_n=0 at mid-burst -> all outputs 0 next edge; fresh start gives bitstream identical to first post-reset burst.
- start asserted in the done cycle -> new burst begins, stream_valid=1 the following cycle.
